// File: rtl/io_hex_display.sv
// Memory-mapped 8-digit hex display peripheral. It holds four data bytes plus dp and blank masks,
// scans a multiplexed active-low 7-segment display, and returns synchronized switch readback.
module io_hex_display #(
    parameter logic [7:0]  BASE_ADDR = 8'h10,
    parameter int unsigned PRESCALE  = 1000
) (
    input  logic       i_oszClk,
    input  logic       i_resetn,
    input  logic [7:0] i_ioAddress,
    input  logic       i_ioNCE,
    input  logic       i_ioNOE,
    input  logic       i_ioNWE,
    input  logic [7:0] i_busData,
    output logic [7:0] o_busData,
    output logic       o_busNOE,
    input  logic [7:0] i_switches,
    output logic [7:0] o_cathodes,
    output logic [7:0] o_anodes
);

    localparam logic [15:0] LP_PRESCALE_M1 = 16'(PRESCALE - 1);

    logic [7:0]  r_data0, r_data1, r_data2, r_data3;
    logic [7:0]  r_dpmask, r_blank;
    logic [7:0]  r_sw_meta, r_sw_sync;
    logic        r_wr_prev;
    logic [15:0] r_prescale;
    logic [2:0]  r_digit;
    logic [7:0]  r_anodes, r_cathodes;

    logic [7:0]  w_offset;
    logic        w_in_win;
    logic        w_wr_act;
    logic        w_wr_pulse;
    logic        w_rd_act;
    logic [3:0]  w_nibble;
    logic [7:0]  w_anodes_d, w_cathodes_d;

    // Modular subtraction: addresses below BASE wrap to large offsets and fall outside the window.
    assign w_offset   = i_ioAddress - BASE_ADDR;
    assign w_in_win   = (w_offset < 8'd7);
    assign w_wr_act   = ~i_ioNCE & ~i_ioNWE & w_in_win;
    assign w_wr_pulse = w_wr_act & ~r_wr_prev;
    assign w_rd_act   = ~i_ioNCE & ~i_ioNOE & w_in_win;

    function automatic logic [6:0] f_seg7(input logic [3:0] i_nib);
        logic [6:0] w_seg;
        unique case (i_nib)
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h06;
            4'h2: w_seg = 7'h5B;
            4'h3: w_seg = 7'h4F;
            4'h4: w_seg = 7'h66;
            4'h5: w_seg = 7'h6D;
            4'h6: w_seg = 7'h7D;
            4'h7: w_seg = 7'h07;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h6F;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h7C;
            4'hC: w_seg = 7'h39;
            4'hD: w_seg = 7'h5E;
            4'hE: w_seg = 7'h79;
            default: w_seg = 7'h71;
        endcase
        return w_seg;
    endfunction

    // One write per strobe assertion: only the rising edge of wrAct commits.
    always_ff @(posedge i_oszClk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_data0   <= 8'h00;
            r_data1   <= 8'h00;
            r_data2   <= 8'h00;
            r_data3   <= 8'h00;
            r_dpmask  <= 8'h00;
            r_blank   <= 8'h00;
            r_wr_prev <= 1'b0;
        end else begin
            r_wr_prev <= w_wr_act;
            if (w_wr_pulse) begin
                case (w_offset)
                    8'd0:    r_data0  <= i_busData;
                    8'd1:    r_data1  <= i_busData;
                    8'd2:    r_data2  <= i_busData;
                    8'd3:    r_data3  <= i_busData;
                    8'd4:    r_dpmask <= i_busData;
                    8'd5:    r_blank  <= i_busData;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_oszClk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_sw_meta <= 8'h00;
            r_sw_sync <= 8'h00;
        end else begin
            r_sw_meta <= i_switches;
            r_sw_sync <= r_sw_meta;
        end
    end

    always_ff @(posedge i_oszClk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_prescale <= 16'd0;
            r_digit    <= 3'd0;
        end else if (r_prescale == LP_PRESCALE_M1) begin
            r_prescale <= 16'd0;
            r_digit    <= r_digit + 3'd1;
        end else begin
            r_prescale <= r_prescale + 16'd1;
        end
    end

    always_comb begin
        w_nibble = 4'h0;
        unique case (r_digit)
            3'd0: w_nibble = r_data0[3:0];
            3'd1: w_nibble = r_data0[7:4];
            3'd2: w_nibble = r_data1[3:0];
            3'd3: w_nibble = r_data1[7:4];
            3'd4: w_nibble = r_data2[3:0];
            3'd5: w_nibble = r_data2[7:4];
            3'd6: w_nibble = r_data3[3:0];
            default: w_nibble = r_data3[7:4];
        endcase
    end

    always_comb begin
        w_anodes_d   = 8'hFF;
        w_cathodes_d = 8'hFF;
        if (!r_blank[r_digit]) begin
            w_anodes_d   = ~(8'h01 << r_digit);
            w_cathodes_d = ~{r_dpmask[r_digit], f_seg7(w_nibble)};
        end
    end

    always_ff @(posedge i_oszClk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_anodes   <= 8'hFF;
            r_cathodes <= 8'hFF;
        end else begin
            r_anodes   <= w_anodes_d;
            r_cathodes <= w_cathodes_d;
        end
    end

    assign o_anodes   = r_anodes;
    assign o_cathodes = r_cathodes;
    assign o_busNOE   = ~w_rd_act;

    always_comb begin
        o_busData = 8'h00;
        if (w_rd_act) begin
            case (w_offset)
                8'd0:    o_busData = r_data0;
                8'd1:    o_busData = r_data1;
                8'd2:    o_busData = r_data2;
                8'd3:    o_busData = r_data3;
                8'd4:    o_busData = r_dpmask;
                8'd5:    o_busData = r_blank;
                8'd6:    o_busData = r_sw_sync;
                default: o_busData = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_io_hex_display.sv
// Bench for io_hex_display: a cycle-count based reference model checked every cycle, plus
// directed literal checks and a randomized bus/switch/reset phase.
module tb_io_hex_display;

    localparam logic [7:0] BASE = 8'h10;
    localparam int         P    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       nce = 1'b1;
    logic       noe = 1'b1;
    logic       nwe = 1'b1;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       bus_noe;
    logic [7:0] sw = 8'h00;
    logic [7:0] cat;
    logic [7:0] an;

    int total = 0;
    int bad = 0;
    logic cmp_en = 1'b0;

    io_hex_display #(
        .BASE_ADDR(BASE),
        .PRESCALE (P)
    ) dut (
        .i_oszClk   (clk),
        .i_resetn   (rst_n),
        .i_ioAddress(addr),
        .i_ioNCE    (nce),
        .i_ioNOE    (noe),
        .i_ioNWE    (nwe),
        .i_busData  (wdata),
        .o_busData  (rdata),
        .o_busNOE   (bus_noe),
        .i_switches (sw),
        .o_cathodes (cat),
        .o_anodes   (an)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state: register file, switch history, edges since reset, expected display outputs.
    logic [7:0]  m_reg [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0]  m_sw1 = 8'h00;
    logic [7:0]  m_sw2 = 8'h00;
    logic        m_prev = 1'b0;
    int          m_n = 0;
    logic [7:0]  m_an = 8'hFF;
    logic [7:0]  m_cat = 8'hFF;
    int          m_d;
    logic [31:0] m_word;
    logic [3:0]  m_nib;
    logic        m_wr;

    function automatic logic in_window(input logic [7:0] a);
        return (int'(a) >= int'(BASE)) && (int'(a) <= int'(BASE) + 6);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) m_reg[i] = 8'h00;
            m_sw1  = 8'h00;
            m_sw2  = 8'h00;
            m_prev = 1'b0;
            m_n    = 0;
            m_an   = 8'hFF;
            m_cat  = 8'hFF;
        end else begin
            m_d    = (m_n / P) % 8;
            m_word = {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
            m_nib  = 4'((m_word >> (4 * m_d)) & 32'hF);
            if (m_reg[5][m_d]) begin
                m_an  = 8'hFF;
                m_cat = 8'hFF;
            end else begin
                m_an  = ~(8'(1) << m_d);
                m_cat = ~{m_reg[4][m_d], seg_tab[m_nib]};
            end
            m_n++;
            m_wr = !nce && !nwe && in_window(addr);
            if (m_wr && !m_prev && (int'(addr) - int'(BASE)) < 6)
                m_reg[int'(addr) - int'(BASE)] = wdata;
            m_prev = m_wr;
            m_sw2  = m_sw1;
            m_sw1  = sw;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [7:0] e_data;
            logic       e_noe;
            e_noe  = !(!nce && !noe && in_window(addr));
            e_data = 8'h00;
            if (!e_noe) e_data = (addr == BASE + 8'd6) ? m_sw2 : m_reg[int'(addr) - int'(BASE)];
            chk("model_anodes", an, m_an);
            chk("model_cathodes", cat, m_cat);
            chk("model_busNOE", {7'h0, bus_noe}, {7'h0, e_noe});
            chk("model_busData", rdata, e_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int off, input logic [7:0] v);
        tick();
        nce = 1'b0; nwe = 1'b0; addr = BASE + 8'(off); wdata = v;
        tick();
        nce = 1'b1; nwe = 1'b1;
    endtask

    // Call at a negedge; returns at the first negedge where anodes equals v, bounded.
    task automatic wait_an(input logic [7:0] v, input string nm);
        int k = 0;
        while (an !== v && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(nm, an, v);
    endtask

    initial begin
        logic [7:0] exp_an;
        repeat (10) tick();
        @(negedge clk);
        chk("rst_anodes", an, 8'hFF);
        chk("rst_cathodes", cat, 8'hFF);
        chk("rst_busNOE", {7'h0, bus_noe}, 8'h01);
        chk("rst_busData", rdata, 8'h00);
        cmp_en = 1'b1;

        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_anodes", an, 8'hFF);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            exp_an = ~(8'h01 << ((n - 1) / 4 % 8));
            chk("scan_anodes", an, exp_an);
            chk("scan_cathodes", cat, 8'hC0);
        end

        // Data changes mid-strobe must not be written.
        tick();
        nce = 1'b0; nwe = 1'b0; addr = BASE; wdata = 8'h3A;
        tick();
        wdata = 8'h55;
        tick();
        tick();
        nwe = 1'b1; noe = 1'b0;
        @(negedge clk);
        chk("data0_read", rdata, 8'h3A);
        chk("data0_noe", {7'h0, bus_noe}, 8'h00);
        tick();
        nce = 1'b1; noe = 1'b1;
        @(negedge clk);
        wait_an(8'hFE, "wait_digit0");
        chk("digit0_cat", cat, 8'h88);
        wait_an(8'hFD, "wait_digit1");
        chk("digit1_cat", cat, 8'hB0);

        wr(4, 8'h01);
        wr(5, 8'h02);
        @(negedge clk);
        wait_an(8'hFE, "wait_dp_digit0");
        chk("dp_digit0_cat", cat, 8'h08);
        for (int k = 0; k < 100 && an === 8'hFE; k++) @(negedge clk);
        chk("blank_digit1_an", an, 8'hFF);
        chk("blank_digit1_cat", cat, 8'hFF);
        wr(5, 8'h00);
        wr(4, 8'h00);

        tick();
        sw = 8'h2A; nce = 1'b0; noe = 1'b0; addr = BASE + 8'd6;
        @(negedge clk);
        chk("sw_lat0", rdata, 8'h00);
        tick();
        @(negedge clk);
        chk("sw_lat1", rdata, 8'h00);
        tick();
        @(negedge clk);
        chk("sw_lat2", rdata, 8'h2A);
        chk("sw_noe", {7'h0, bus_noe}, 8'h00);
        nwe = 1'b0; wdata = 8'hFF;
        tick();
        tick();
        nwe = 1'b1;
        @(negedge clk);
        chk("sw_write_ignored", rdata, 8'h2A);
        addr = BASE + 8'd7;
        #1;
        chk("oob_hi_noe", {7'h0, bus_noe}, 8'h01);
        chk("oob_hi_data", rdata, 8'h00);
        addr = 8'h00;
        #1;
        chk("oob_zero_noe", {7'h0, bus_noe}, 8'h01);
        chk("oob_zero_data", rdata, 8'h00);
        tick();
        nce = 1'b1; noe = 1'b1;

        // Reset mid-write: write discarded.
        tick();
        nce = 1'b0; nwe = 1'b0; addr = BASE + 8'd1; wdata = 8'h77;
        tick();
        rst_n = 1'b0; nce = 1'b1; nwe = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        nce = 1'b0; noe = 1'b0; addr = BASE + 8'd1;
        @(negedge clk);
        chk("rst_mid_discard", rdata, 8'h00);

        // Strobe held through reset release counts as a fresh edge.
        tick();
        nwe = 1'b0; wdata = 8'h77;
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_held_before", rdata, 8'h00);
        tick();
        @(negedge clk);
        chk("rst_held_written", rdata, 8'h77);
        tick();
        nce = 1'b1; nwe = 1'b1; noe = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n = ($urandom_range(0, 199) != 0);
            nce   = ($urandom_range(0, 3) == 0);
            nwe   = ($urandom_range(0, 2) != 0);
            noe   = ($urandom_range(0, 1) != 0);
            addr  = BASE - 8'd2 + 8'($urandom_range(0, 10));
            wdata = 8'($urandom);
            if ($urandom_range(0, 15) == 0) sw = 8'($urandom);
        end
        tick();
        rst_n = 1'b1; nce = 1'b1; nwe = 1'b1; noe = 1'b1;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_hex_display.md
Name: io_hex_display

Overview:
- Memory-mapped I/O peripheral on the CPU's I/O bus, directly downstream of the CPU core.
- Consumes the core's I/O strobes: address, nCE, nOE, nWE and write data.
- Holds four display bytes shown as 8 hex digits on a multiplexed, active-low 7-segment display, plus decimal-point and blanking masks.
- Returns synchronized switch values and register readback onto the core's input bus.

Parameters:
BASE_ADDR, 8'h10, first I/O address of the 7-register window (BASE..BASE+6)
PRESCALE, 1000, clock cycles each digit is lit; legal range 2..65535

Ports:
i_oszClk  in  1  system clock
i_resetn  in  1  asynchronous active-low reset
i_ioAddress  in  8  I/O address from core
i_ioNCE  in  1  I/O chip enable, active low
i_ioNOE  in  1  I/O output enable (read), active low
i_ioNWE  in  1  I/O write enable, active low
i_busData  in  8  write data from core
o_busData  out  8  read data to core
o_busNOE  out  1  read data valid, active low
i_switches  in  8  raw board switches, asynchronous
o_cathodes  out  8  segments {dp,g,f,e,d,c,b,a}, active low
o_anodes  out  8  digit select, active low one-hot

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0..3 DATA0..DATA3 (R/W).
  - 4 DPMASK (R/W): bit i lights the dp of digit i.
  - 5 BLANK (R/W): bit i forces digit i dark.
  - 6 SWITCH (R only; writes ignored).
  - Addresses outside BASE..BASE+6 are not decoded.
- Reset (async, on i_resetn low):
  - All registers 0; switch synchronizer flops 0.
  - Prescale counter 0; digit index 0; write-edge flop 0.
  - o_anodes=8'hFF; o_cathodes=8'hFF.
  - o_busNOE=1; o_busData=8'h00.
- Write:
  - wrAct = !i_ioNCE & !i_ioNWE & address in window, sampled at posedge.
  - The register is written at the first posedge where wrAct=1 and the previous-cycle wrAct=0.
  - Exactly one write per strobe assertion; address or data changes while the strobe is held are ignored.
  - A write to offset 6 consumes the edge and has no effect.
- Read (combinational, same cycle):
  - o_busNOE = !(!i_ioNCE & !i_ioNOE & address in window).
  - o_busData = the addressed register when o_busNOE=0, else 8'h00.
  - If nOE and nWE are low together, the write proceeds and readback shows the old value until the next posedge.
- Switches: 2-flop synchronizer. SWITCH returns the second flop, so latency is 2 cycles from an i_switches change.
- Scan:
  - Prescale counter runs 0..PRESCALE-1 and wraps to 0.
  - On the wrap cycle the digit index increments modulo 8 (7 -> 0).
- Digit mapping: digit d shows nibble d of {DATA3,DATA2,DATA1,DATA0}; digit 0 = DATA0[3:0], digit 7 = DATA3[7:4].
- Output registers, updated every cycle from the current digit index and register contents:
  - o_anodes = ~(1<<d), or 8'hFF if BLANK[d].
  - o_cathodes = ~{DPMASK[d], seg7(nibble)}; 8'hFF if BLANK[d].
  - Outputs therefore trail an index change or register write by 1 cycle.
- seg7 encodings (gfedcba, active high before inversion):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Reset mid-strobe: the write is discarded. After reset release, a still-held strobe counts as a new edge and is written.

Test Plan:
- Reset, then hold 10 cycles -> o_anodes=FF, o_cathodes=FF, o_busNOE=1, o_busData=00; first lit digit appears with anodes=FE, cathodes=C0.
- Write DATA0=8'h3A (nCE=nWE=0 for 3 cycles, data changed to 8'h55 on cycle 2) -> DATA0 reads 3A; digit0 cathodes=~8'h77=88, digit1 cathodes=~8'h4F=B0.
- PRESCALE=4: run 40 cycles -> anodes sequence FE,FD,...,7F,FE, each held exactly 4 cycles, wrapping 7->0.
- DPMASK=8'h01, BLANK=8'h02 -> digit0 cathodes bit7=0; during digit1 slot anodes=FF, cathodes=FF.
- i_switches=8'h2A, then read offset 6 -> o_busNOE=0, o_busData=2A from the 3rd cycle after the change; a write of 8'hFF to offset 6 leaves the readback at 2A.
- Read address BASE+7 and 8'h00 -> o_busNOE=1, o_busData=00; assert i_resetn=0 mid-write of DATA1=8'h77 -> DATA1 reads 00 after release, and reads 77 if the strobe is still held.
